// File: rtl/cache_meta_nway.sv
// N-way set-associative tag/valid/LRU-age store with registered lookup, fills and an invalidate-all sweep.
// Optional hit/miss performance counters are enabled by defining PERF_CNT_EN.
module cache_meta_nway #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 6,
  localparam int unsigned WAY_W = $clog2(WAYS),
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [SET_W-1:0] lookup_set,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             resp_valid,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] victim_way,
  input  logic             fill_valid,
  input  logic [SET_W-1:0] fill_set,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_all_req,
  output logic             busy,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_row_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [SET_W-1:0]           cnt_q;
  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0] tag_q   [SETS];
  age_row_t                   age_q   [SETS];

  logic                       accept_c, sweep_c, sweep_start_c;
  logic                       lookup_acc_c, fill_acc_c;
  logic [WAYS-1:0]            rd_valid_c;
  logic [WAYS-1:0][TAG_W-1:0] rd_tag_c;
  age_row_t                   rd_age_c;
  logic                       hit_c;
  logic [WAY_W-1:0]           hit_way_c, victim_c;

  function automatic age_row_t age_init();
    age_row_t r;
    for (int w = 0; w < WAYS; w++) r[WAY_W'(w)] = WAY_W'(w);
    return r;
  endfunction

  // Move one way to MRU; ways that were younger than it age by one.
  function automatic age_row_t touch(input age_row_t r, input logic [WAY_W-1:0] way);
    age_row_t n;
    n = r;
    for (int w = 0; w < WAYS; w++)
      if (r[WAY_W'(w)] < r[way]) n[WAY_W'(w)] = r[WAY_W'(w)] + WAY_W'(1);
    n[way] = '0;
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (inv_all_req) state_d = ST_SWEEP;
      ST_SWEEP: if (cnt_q == SET_W'(SETS - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_c      = 1'b0;
    sweep_c       = 1'b0;
    sweep_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept_c      = 1'b1;
        sweep_start_c = inv_all_req;
      end
      ST_SWEEP: sweep_c = 1'b1;
      default: ;
    endcase
  end

  assign lookup_acc_c = lookup_valid && accept_c;
  assign fill_acc_c   = fill_valid && accept_c;

  // Tag compare and victim selection on pre-edge contents; lowest index wins.
  always_comb begin
    rd_valid_c = valid_q[lookup_set];
    rd_tag_c   = tag_q[lookup_set];
    rd_age_c   = age_q[lookup_set];
    hit_c      = 1'b0;
    hit_way_c  = '0;
    victim_c   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_valid_c[WAY_W'(w)] && (rd_tag_c[WAY_W'(w)] == lookup_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++)
      if (rd_age_c[WAY_W'(w)] == WAY_W'(WAYS - 1)) victim_c = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!rd_valid_c[WAY_W'(w)]) victim_c = WAY_W'(w);
  end

  // Metadata arrays: sweep clears one set per cycle, otherwise fill/lookup touches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[SET_W'(s)] <= '0;
        tag_q[SET_W'(s)]   <= '0;
        age_q[SET_W'(s)]   <= age_init();
      end
    end else if (sweep_c) begin
      valid_q[cnt_q] <= '0;
      age_q[cnt_q]   <= age_init();
    end else begin
      if (lookup_acc_c && hit_c && !(fill_acc_c && (fill_set == lookup_set)))
        age_q[lookup_set] <= touch(rd_age_c, hit_way_c);
      if (fill_acc_c) begin
        tag_q[fill_set][fill_way]   <= fill_tag;
        valid_q[fill_set][fill_way] <= 1'b1;
        age_q[fill_set]             <= touch(age_q[fill_set], fill_way);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt_q <= '0;
    else if (sweep_c) cnt_q <= cnt_q + SET_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid   <= 1'b0;
      hit          <= 1'b0;
      hit_way      <= '0;
      victim_way   <= '0;
      busy         <= 1'b0;
      lookup_ready <= 1'b1;
    end else begin
      resp_valid   <= lookup_acc_c;
      busy         <= (state_d == ST_SWEEP);
      lookup_ready <= (state_d == ST_IDLE);
      if (lookup_acc_c) begin
        hit        <= hit_c;
        hit_way    <= hit_way_c;
        victim_way <= victim_c;
      end
    end
  end

`ifdef PERF_CNT_EN
  // Saturating hit/miss counters, cleared when a sweep starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (sweep_start_c) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`else
  assign hit_count  = 16'h0;
  assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_cache_meta_nway.sv
// Bench for cache_meta_nway: recency-list model checked every cycle plus directed literal checks.
module tb_cache_meta_nway;
  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 6;
  localparam int SET_W = 6;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lookup_valid = 1'b0;
  logic             lookup_ready;
  logic [SET_W-1:0] lookup_set = '0;
  logic [TAG_W-1:0] lookup_tag = '0;
  logic             resp_valid;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             fill_valid = 1'b0;
  logic [SET_W-1:0] fill_set = '0;
  logic [WAY_W-1:0] fill_way = '0;
  logic [TAG_W-1:0] fill_tag = '0;
  logic             inv_all_req = 1'b0;
  logic             busy;
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  always #5 clk = ~clk;

  cache_meta_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_set(lookup_set), .lookup_tag(lookup_tag),
    .resp_valid(resp_valid), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_all_req(inv_all_req), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per set a valid/tag table plus a recency list (MRU first).
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_order [SETS][WAYS];
  int sweep_left;
  bit exp_rv, exp_hit, l_hit;
  int exp_hw, exp_vw, exp_hc, exp_mc, l_way;

  function automatic void m_clear_set(input int s);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[s][w] = 1'b0;
      m_order[s][w] = w;
    end
  endfunction

  function automatic void m_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    return m_order[s][WAYS-1];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) m_clear_set(s);
      sweep_left = 0;
      exp_rv = 0; exp_hit = 0; exp_hw = 0; exp_vw = 0; exp_hc = 0; exp_mc = 0;
    end else begin
`ifdef PERF_CNT_EN
      if (exp_rv) begin
        if (exp_hit) begin if (exp_hc < 65535) exp_hc++; end
        else if (exp_mc < 65535) exp_mc++;
      end
`endif
      exp_rv = 0;
      if (sweep_left > 0) begin
        m_clear_set(SETS - sweep_left);
        sweep_left--;
      end else begin
        if (lookup_valid) begin
          l_hit = 0; l_way = 0;
          for (int w = WAYS - 1; w >= 0; w--)
            if (m_valid[lookup_set][w] && m_tag[lookup_set][w] == int'(lookup_tag)) begin
              l_hit = 1; l_way = w;
            end
          exp_rv = 1; exp_hit = l_hit; exp_hw = l_way; exp_vw = m_victim(int'(lookup_set));
          if (l_hit && !(fill_valid && fill_set == lookup_set)) m_touch(int'(lookup_set), l_way);
        end
        if (fill_valid) begin
          m_valid[fill_set][fill_way] = 1'b1;
          m_tag[fill_set][fill_way]   = int'(fill_tag);
          m_touch(int'(fill_set), int'(fill_way));
        end
        if (inv_all_req) begin
          sweep_left = SETS; exp_hc = 0; exp_mc = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        check("hit", hit, exp_hit);
        check("hit_way", hit_way, exp_hw);
        check("victim_way", victim_way, exp_vw);
      end
      check("busy", busy, sweep_left > 0);
      check("lookup_ready", lookup_ready, sweep_left == 0);
      check("hit_count", hit_count, exp_hc);
      check("miss_count", miss_count, exp_mc);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic lookup(input int s, input int t);
    lookup_valid = 1'b1; lookup_set = SET_W'(s); lookup_tag = TAG_W'(t);
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic fill(input int s, input int w, input int t);
    fill_valid = 1'b1; fill_set = SET_W'(s); fill_way = WAY_W'(w); fill_tag = TAG_W'(t);
    step();
    fill_valid = 1'b0;
  endtask

  task automatic lookup_fill(input int ls, input int lt, input int fs, input int fw, input int ft);
    lookup_valid = 1'b1; lookup_set = SET_W'(ls); lookup_tag = TAG_W'(lt);
    fill_valid = 1'b1; fill_set = SET_W'(fs); fill_way = WAY_W'(fw); fill_tag = TAG_W'(ft);
    step();
    lookup_valid = 1'b0; fill_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", lookup_ready, 1);
    check("rst_victim", victim_way, 0);
    check("rst_hit_count", hit_count, 0);
    rst = 1'b1;
    cmp_en = 1'b1;
    step();

    // 1: lookup into an empty set
    lookup(5, 'h2A);
    check("t1_rv", resp_valid, 1);
    check("t1_hit", hit, 0);
    check("t1_victim", victim_way, 0);
    check("t1_model_vw", exp_vw, 0);

    // 2: fill all ways, hits and LRU victim
    for (int w = 0; w < 4; w++) fill(5, w, 'h10 + w);
    lookup(5, 'h12);
    check("t2_hit", hit, 1);
    check("t2_hit_way", hit_way, 2);
    check("t2_model_hw", exp_hw, 2);
    lookup(5, 'h3F);
    check("t2_miss", hit, 0);
    check("t2_victim", victim_way, 0);
    lookup(5, 'h10);
    lookup(5, 'h3E);
    check("t2_victim_lru", victim_way, 1);
    lookup_fill(5, 'h11, 9, 0, 'h13);
    check("t2_split_hit_way", hit_way, 1);
    lookup(5, 'h3E);
    check("t2_victim_after_split", victim_way, 3);
    lookup(9, 'h13);
    check("t2_other_set_hit", hit, 1);

    // 3: sweep with a lookup issued in the start cycle; inputs ignored while busy
    lookup_valid = 1'b1; lookup_set = 6'd5; lookup_tag = 6'h12; inv_all_req = 1'b1;
    step();
    lookup_valid = 1'b0; inv_all_req = 1'b0;
    check("t3_rv_at_start", resp_valid, 1);
    check("t3_hit_at_start", hit, 1);
    check("t3_ready_low", lookup_ready, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 10) begin
        lookup_valid = 1'b1; fill_valid = 1'b1;
        fill_set = 6'd5; fill_way = 2'd2; fill_tag = 6'h12;
      end
      step();
      lookup_valid = 1'b0; fill_valid = 1'b0;
    end
    check("t3_busy_cycles", n, 64);
    check("t3_ready_back", lookup_ready, 1);
    lookup(5, 'h12);
    check("t3_hit_after_sweep", hit, 0);
    check("t3_victim_after_sweep", victim_way, 0);

    // 4: fill and lookup of the same set/tag in one cycle
    lookup_fill(7, 'h05, 7, 1, 'h05);
    check("t4_same_cycle_hit", hit, 0);
    lookup(7, 'h05);
    check("t4_relookup_hit", hit, 1);
    check("t4_relookup_way", hit_way, 1);

    // 5: reset in the middle of a sweep
    inv_all_req = 1'b1;
    step();
    inv_all_req = 1'b0;
    repeat (20) step();
    rst = 1'b0;
    #1;
    check("t5_busy_reset", busy, 0);
    check("t5_ready_reset", lookup_ready, 1);
    step();
    rst = 1'b1;
    lookup(7, 'h05);
    check("t5_hit_after_reset", hit, 0);
    lookup(9, 'h13);
    check("t5_hit2_after_reset", hit, 0);

    // 6: performance counters from a clean reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    fill(3, 0, 'h01);
    fill(3, 1, 'h02);
    lookup(3, 'h01);
    lookup(3, 'h02);
    lookup(3, 'h01);
    lookup(3, 'h09);
    lookup(10, 'h01);
    step();
`ifdef PERF_CNT_EN
    check("t6_hit_count", hit_count, 3);
    check("t6_miss_count", miss_count, 2);
`else
    check("t6_hit_count", hit_count, 0);
    check("t6_miss_count", miss_count, 0);
`endif
    inv_all_req = 1'b1;
    step();
    inv_all_req = 1'b0;
    check("t6_clear_on_sweep", hit_count, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check("t6_sweep_done", busy, 0);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
